// File: rtl/des_decrypt_core_pkg.sv
// Shared DES constants (FIPS 46-3 tables), FSM encoding and table-driven
// permutation helpers used by the decrypt core and its round function.
package des_decrypt_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // All tables use DES 1-based bit numbering; bit 1 is the MSB of the vector.
    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int FP_TBL [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // SHIFT[1..16] stored at index 0..15.
    localparam int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Each S-box is 64 nibbles, row-major (row*16 + col), entry 0 in the top nibble.
    localparam logic [255:0] SBOX_TBL [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[i])];
        return y;
    endfunction

    // True when SHIFT[n] (n = 1..16) is a double rotation.
    function automatic logic shift_two(input logic [4:0] n);
        return SHIFT_TBL[4'(n - 5'd1)] == 2;
    endfunction

endpackage

// File: rtl/des_decrypt_core_f.sv
// DES round function f(R, K) = P(S1..S8(E(R) xor K)), purely combinational,
// built from eight table-driven S-box instances.
module des_sbox
    import des_decrypt_core_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic [5:0] din,
    output logic [3:0] dout
);

    localparam logic [255:0] TBL = SBOX_TBL[IDX];

    // Outer bits select the row, inner four bits the column.
    logic [5:0] sel;

    assign sel  = {din[5], din[0], din[4:1]};
    assign dout = TBL[8'd255 - {sel, 2'b00} -: 4];

endmodule

module des_f
    import des_decrypt_core_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);

    logic [47:0] x;
    logic [31:0] s;

    assign x = e_expand(r) ^ k;

    for (genvar i = 0; i < 8; i++) begin : g_sbox
        des_sbox #(.IDX(i)) u_sbox (
            .din  (x[47 - 6*i -: 6]),
            .dout (s[31 - 4*i -: 4])
        );
    end

    assign f = p_perm(s);

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, subkeys generated
// on the fly by rotating C/D right so round 1 uses K16.
module des_decrypt_core
    import des_decrypt_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out,
    output logic        busy
);

    state_t      state, state_nxt;
    logic [4:0]  round;
    logic [31:0] l, r, f_out;
    logic [27:0] c, d;
    logic [47:0] subkey;
    logic [63:0] ip_in;
    logic [55:0] cd_init;
    logic        accept, handshake, last_round;

    assign accept     = in_valid & in_ready;
    assign handshake  = out_valid & out_ready;
    assign last_round = (round == 5'd16);
    assign ip_in      = ip_perm(data_in);
    assign cd_init    = pc1_perm(key);
    assign subkey     = pc2_perm({c, d});

    des_f u_f (
        .r (r),
        .k (subkey),
        .f (f_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept)     state_nxt = ST_RUN;
            ST_RUN:  if (last_round) state_nxt = ST_DONE;
            ST_DONE: if (handshake)  state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN,
            ST_DONE: busy     = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the datapath registers are reset too, so an aborted block leaves
    // no key or text material behind and data_out reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round     <= 5'd0;
            l         <= 32'h0;
            r         <= 32'h0;
            c         <= 28'h0;
            d         <= 28'h0;
            data_out  <= 64'h0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        l     <= ip_in[63:32];
                        r     <= ip_in[31:0];
                        c     <= cd_init[55:28];
                        d     <= cd_init[27:0];
                        round <= 5'd1;
                    end
                end
                ST_RUN: begin
                    l <= r;
                    r <= l ^ f_out;
                    if (!last_round) begin
                        round <= round + 5'd1;
                        // Undo the encryption-side left shift of round 17-r.
                        if (shift_two(5'd17 - round)) begin
                            c <= {c[1:0], c[27:2]};
                            d <= {d[1:0], d[27:2]};
                        end else begin
                            c <= {c[0], c[27:1]};
                            d <= {d[0], d[27:1]};
                        end
                    end
                end
                ST_DONE: begin
                    if (!out_valid) begin
                        data_out  <= fp_perm({r, l});
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_core.sv
// Self-checking bench for des_decrypt_core: known answers, random blocks
// against a forward-encryption model, backpressure, reset abort, back-to-back.
`timescale 1ns/1ps
module tb_des_decrypt_core;
    import des_decrypt_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] data_in, key, data_out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
    localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] CT2 = 64'h0000000000000000;
    localparam logic [63:0] PT2 = 64'h8787878787878787;

    des_decrypt_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference f built straight from the table definitions.
    function automatic logic [31:0] ref_f(input logic [31:0] rh, input logic [47:0] sk);
        logic [47:0]  x;
        logic [31:0]  s;
        logic [255:0] box;
        int           six, idx;
        x = e_expand(rh) ^ sk;
        for (int b = 0; b < 8; b++) begin
            six = int'(x[47 - 6*b -: 6]);
            idx = ((six >> 5) & 1) * 32 + (six & 1) * 16 + ((six >> 1) & 15);
            box = SBOX_TBL[b];
            s[31 - 4*b -: 4] = box[255 - 4*idx -: 4];
        end
        return p_perm(s);
    endfunction

    // Forward DES encryption: subkeys K1..K16 by cumulative left shifts.
    function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [63:0] k);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] x;
        logic [31:0] lh, rh, t;
        cd = pc1_perm(k);
        c  = cd[55:28];
        d  = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < SHIFT_TBL[n]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[n] = pc2_perm({c, d});
        end
        x  = ip_perm(pt);
        lh = x[63:32];
        rh = x[31:0];
        for (int n = 0; n < 16; n++) begin
            t  = rh;
            rh = lh ^ ref_f(rh, ks[n]);
            lh = t;
        end
        return fp_perm({rh, lh});
    endfunction

    // Submit one block, scramble inputs after accept, check latency and result.
    task automatic run_block(input logic [63:0] ct, input logic [63:0] k,
                             input logic [63:0] exp_pt, input string tag, input bit poke);
        bit seen;
        int lat;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        check({tag, "_ready"}, 64'(seen), 64'd1);
        in_valid = 1'b1;
        data_in  = ct;
        key      = k;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom};
        key      = {$urandom, $urandom};
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_not_ready"}, 64'(in_ready), 64'd0);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 40; i++) begin
            if (poke && i == 5) begin
                in_valid = 1'b1;
                data_in  = {$urandom, $urandom};
                key      = {$urandom, $urandom};
            end
            if (poke && i == 6) in_valid = 1'b0;
            @(posedge clk); #1;
            if (out_valid) begin seen = 1'b1; lat = i; break; end
        end
        check({tag, "_out_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'd17);
        check({tag, "_data"}, data_out, exp_pt);
        if (out_ready) begin
            @(posedge clk); #1;
            check({tag, "_out_drop"}, 64'(out_valid), 64'd0);
            check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        logic [63:0] pt, k, ct;
        logic        rdy_q;
        int          cyc, n_acc, n_out, busy_cnt;
        int          acc_t [2];
        int          out_t [2];
        logic [63:0] out_d [2];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = 64'h0;
        key       = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data_out", data_out, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_release_ready", 64'(in_ready), 64'd1);

        run_block(CT1, K1, PT1, "kat1", 1'b0);
        run_block(CT2, K2, PT2, "kat2", 1'b0);
        run_block(CT1, K1, PT1, "busy_ignore", 1'b1);

        for (int i = 0; i < 6; i++) begin
            pt = {$urandom, $urandom};
            k  = {$urandom, $urandom};
            ct = ref_encrypt(pt, k);
            run_block(ct, k, pt, "rand", 1'b0);
        end

        // Backpressure with a competing in_valid held through the handshake.
        pt = {$urandom, $urandom};
        k  = {$urandom, $urandom};
        out_ready = 1'b0;
        run_block(ref_encrypt(pt, k), k, pt, "bp", 1'b0);
        in_valid = 1'b1;
        data_in  = {$urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data", data_out, pt);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_handshake_drop", 64'(out_valid), 64'd0);
        check("bp_no_accept_busy", 64'(busy), 64'd0);
        check("bp_ready_after", 64'(in_ready), 64'd1);
        in_valid = 1'b0;

        // Abort at round 8 with a stale nonzero data_out in the register.
        in_valid = 1'b1;
        data_in  = CT1;
        key      = K1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_data_out", data_out, 64'h0);
        check("abort_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready_after", 64'(in_ready), 64'd1);
        check("abort_no_output", 64'(out_valid), 64'd0);
        run_block(CT1, K1, PT1, "abort_rerun", 1'b0);

        // Back-to-back with in_valid held high and out_ready high.
        cyc      = 0;
        n_acc    = 0;
        n_out    = 0;
        busy_cnt = 0;
        in_valid = 1'b1;
        data_in  = CT1;
        key      = K1;
        for (int i = 0; i < 80 && n_out < 2; i++) begin
            rdy_q = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy_q && in_valid) begin
                acc_t[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    data_in = CT2;
                    key     = K2;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (busy && n_acc == 1) busy_cnt++;
            if (out_valid && out_ready) begin
                out_d[n_out] = data_out;
                out_t[n_out] = cyc;
                n_out++;
            end
        end
        in_valid = 1'b0;
        check("b2b_out_count", 64'(n_out), 64'd2);
        if (n_out == 2 && n_acc == 2) begin
            check("b2b_first_data", out_d[0], PT1);
            check("b2b_second_data", out_d[1], PT2);
            check("b2b_first_latency", 64'(out_t[0] - acc_t[0]), 64'd17);
            check("b2b_second_latency", 64'(out_t[1] - acc_t[1]), 64'd17);
            check("b2b_busy_cycles", 64'(busy_cnt), 64'd18);
        end
        @(posedge clk); #1;
        check("b2b_final_ready", 64'(in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
